// File: rtl/multiplier_pad_table.sv
`default_nettype none
// ============================================================================
//  Module   : multiplier_pad_table
//  Purpose  : Eight-slot landing-pad table (X/Y centre + 3-bit multiplier).
//             Feeds the PosX_n/PosY_n inputs of the multiplier sprite renderers
//             and, on a touchdown pulse, runs a one-slot-per-cycle scan to
//             find the pad under the lander and report its multiplier.
//  Ports    : Clk, Reset (async, active-high)
//             wr_en/wr_idx/wr_x/wr_y/wr_mult : slot write port (mult 0 = empty)
//             clear                          : invalidate all slots
//             touchdown/LanderX/LanderY      : scan request
//             PosX_n/PosY_n/Mult_n (n=0..7)  : slot contents to renderers
//             busy, result_valid, result_hit, result_idx, result_mult
//             blink_on                       : sprite blink phase
//  Options  : define MULT_BLINK_EN to enable the sprite blink counter
//             (BLINK_PERIOD+1 cycles per phase); otherwise blink_on = 1.
//  Revision : 1.0  initial release
// ============================================================================
module multiplier_pad_table #(
    parameter int          HALF_W       = 7,
    parameter int          TOL_Y        = 8,
    parameter int unsigned BLINK_PERIOD = 50000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_idx,
    input  logic [15:0] wr_x,
    input  logic [15:0] wr_y,
    input  logic [2:0]  wr_mult,
    input  logic        clear,
    input  logic        touchdown,
    input  logic [15:0] LanderX,
    input  logic [15:0] LanderY,
    output logic [15:0] PosX_0, PosX_1, PosX_2, PosX_3,
    output logic [15:0] PosX_4, PosX_5, PosX_6, PosX_7,
    output logic [15:0] PosY_0, PosY_1, PosY_2, PosY_3,
    output logic [15:0] PosY_4, PosY_5, PosY_6, PosY_7,
    output logic [2:0]  Mult_0, Mult_1, Mult_2, Mult_3,
    output logic [2:0]  Mult_4, Mult_5, Mult_6, Mult_7,
    output logic        busy,
    output logic        result_valid,
    output logic        result_hit,
    output logic [2:0]  result_idx,
    output logic [2:0]  result_mult,
    output logic        blink_on
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_x    [8];
    logic [15:0] r_y    [8];
    logic [2:0]  r_mult [8];
    logic [15:0] w_pos_x [8];
    logic [15:0] w_pos_y [8];
    logic [15:0] r_lx, r_ly;
    logic [2:0]  r_idx;
    logic        r_hit;
    logic [2:0]  r_res_idx, r_res_mult;
    logic        w_blink;

    // ------------------------------------------------------------------
    // Slot storage. A write to a slot takes priority over clear, so a
    // clear+write cycle leaves only the written slot populated.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < 8; i++) begin : g_slot
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    r_x[i]    <= '0;
                    r_y[i]    <= '0;
                    r_mult[i] <= '0;
                end else if (wr_en && (wr_idx == 3'(i))) begin
                    r_x[i]    <= wr_x;
                    r_y[i]    <= wr_y;
                    r_mult[i] <= wr_mult;
                end else if (clear) begin
                    r_mult[i] <= '0;
                end
            end

            // Empty (or blinked-off) slots park at 16'hFFFF, far outside the
            // renderers' 10-bit draw window.
            assign w_pos_x[i] = ((r_mult[i] != 3'd0) && w_blink) ? r_x[i] : 16'hFFFF;
            assign w_pos_y[i] = ((r_mult[i] != 3'd0) && w_blink) ? r_y[i] : 16'hFFFF;
        end
    endgenerate

    assign PosX_0 = w_pos_x[0];  assign PosY_0 = w_pos_y[0];  assign Mult_0 = r_mult[0];
    assign PosX_1 = w_pos_x[1];  assign PosY_1 = w_pos_y[1];  assign Mult_1 = r_mult[1];
    assign PosX_2 = w_pos_x[2];  assign PosY_2 = w_pos_y[2];  assign Mult_2 = r_mult[2];
    assign PosX_3 = w_pos_x[3];  assign PosY_3 = w_pos_y[3];  assign Mult_3 = r_mult[3];
    assign PosX_4 = w_pos_x[4];  assign PosY_4 = w_pos_y[4];  assign Mult_4 = r_mult[4];
    assign PosX_5 = w_pos_x[5];  assign PosY_5 = w_pos_y[5];  assign Mult_5 = r_mult[5];
    assign PosX_6 = w_pos_x[6];  assign PosY_6 = w_pos_y[6];  assign Mult_6 = r_mult[6];
    assign PosX_7 = w_pos_x[7];  assign PosY_7 = w_pos_y[7];  assign Mult_7 = r_mult[7];

    // ------------------------------------------------------------------
    // Hit test on the slot currently addressed by the scan index. The
    // zero-extended 17-bit difference cannot wrap, so a lander at 65535
    // never matches a pad at 0.
    // ------------------------------------------------------------------
    logic signed [16:0] w_dx, w_dy;
    logic        [16:0] w_adx, w_ady;
    logic               w_hit;

    assign w_dx  = signed'({1'b0, r_lx}) - signed'({1'b0, r_x[r_idx]});
    assign w_dy  = signed'({1'b0, r_ly}) - signed'({1'b0, r_y[r_idx]});
    assign w_adx = w_dx[16] ? 17'(-w_dx) : 17'(w_dx);
    assign w_ady = w_dy[16] ? 17'(-w_dy) : 17'(w_dy);
    assign w_hit = (r_mult[r_idx] != 3'd0) && (w_adx <= 17'(HALF_W)) && (w_ady <= 17'(TOL_Y));

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (touchdown) w_state_nxt = S_SCAN;
            S_SCAN:  if (w_hit || (r_idx == 3'd7)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_lx       <= '0;
            r_ly       <= '0;
            r_idx      <= '0;
            r_hit      <= 1'b0;
            r_res_idx  <= '0;
            r_res_mult <= 3'd1;
        end else begin
            if ((r_state == S_IDLE) && touchdown) begin
                r_lx  <= LanderX;
                r_ly  <= LanderY;
                r_idx <= '0;
            end else if (r_state == S_SCAN) begin
                if (w_hit) begin
                    r_hit      <= 1'b1;
                    r_res_idx  <= r_idx;
                    r_res_mult <= r_mult[r_idx];
                end else if (r_idx == 3'd7) begin
                    r_hit      <= 1'b0;
                    r_res_idx  <= '0;
                    r_res_mult <= 3'd1;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end
        end
    end

    assign busy         = (r_state == S_SCAN);
    assign result_valid = (r_state == S_DONE);
    assign result_hit   = r_hit;
    assign result_idx   = r_res_idx;
    assign result_mult  = r_res_mult;

    // ------------------------------------------------------------------
    // Sprite blink
    // ------------------------------------------------------------------
`ifdef MULT_BLINK_EN
    logic [31:0] r_blink_cnt;
    logic        r_blink;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
        end else if (r_blink_cnt == 32'(BLINK_PERIOD)) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + 32'd1;
        end
    end

    assign w_blink = r_blink;
`else
    assign w_blink = 1'b1;
`endif

    assign blink_on = w_blink;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_pad_table.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multiplier_pad_table
//  Purpose  : Directed self-checking bench for multiplier_pad_table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multiplier_pad_table;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [15:0] wr_x, wr_y;
    logic [2:0]  wr_mult;
    logic        clear, touchdown;
    logic [15:0] LanderX, LanderY;
    logic [15:0] pos_x [8];
    logic [15:0] pos_y [8];
    logic [2:0]  mult  [8];
    logic        busy, result_valid, result_hit, blink_on;
    logic [2:0]  result_idx, result_mult;

    int n_vec  = 0;
    int n_fail = 0;

    // Values captured by run_scan
    int         s_lat, s_pulses, s_busy;
    logic       s_hit;
    logic [2:0] s_idx, s_mult;

    always #5 Clk = ~Clk;

`ifdef MULT_BLINK_EN
    localparam int unsigned C_BLINK = 3;
`else
    localparam int unsigned C_BLINK = 50000000;
`endif

    multiplier_pad_table #(.HALF_W(7), .TOL_Y(8), .BLINK_PERIOD(C_BLINK)) dut (
        .Clk(Clk), .Reset(Reset),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_mult(wr_mult),
        .clear(clear), .touchdown(touchdown), .LanderX(LanderX), .LanderY(LanderY),
        .PosX_0(pos_x[0]), .PosX_1(pos_x[1]), .PosX_2(pos_x[2]), .PosX_3(pos_x[3]),
        .PosX_4(pos_x[4]), .PosX_5(pos_x[5]), .PosX_6(pos_x[6]), .PosX_7(pos_x[7]),
        .PosY_0(pos_y[0]), .PosY_1(pos_y[1]), .PosY_2(pos_y[2]), .PosY_3(pos_y[3]),
        .PosY_4(pos_y[4]), .PosY_5(pos_y[5]), .PosY_6(pos_y[6]), .PosY_7(pos_y[7]),
        .Mult_0(mult[0]), .Mult_1(mult[1]), .Mult_2(mult[2]), .Mult_3(mult[3]),
        .Mult_4(mult[4]), .Mult_5(mult[5]), .Mult_6(mult[6]), .Mult_7(mult[7]),
        .busy(busy), .result_valid(result_valid), .result_hit(result_hit),
        .result_idx(result_idx), .result_mult(result_mult), .blink_on(blink_on)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_slot(input logic [2:0] idx, input logic [15:0] x,
                              input logic [15:0] y, input logic [2:0] m);
        wr_en = 1'b1; wr_idx = idx; wr_x = x; wr_y = y; wr_mult = m;
        tick();
        wr_en = 1'b0;
    endtask

    // Pulses touchdown, then watches 20 cycles. s_lat counts cycles from the
    // touchdown cycle to the first result_valid. Optional retrigger at T+2 and
    // optional slot write (preloaded wr_* fields) at cycle T+wr_cycle.
    task automatic run_scan(input logic [15:0] lx, input logic [15:0] ly,
                            input bit retrig, input int wr_cycle);
        LanderX = lx; LanderY = ly; touchdown = 1'b1;
        tick();
        touchdown = 1'b0;
        s_lat = -1; s_pulses = 0; s_busy = 0;
        for (int c = 1; c <= 20; c++) begin
            touchdown = retrig && (c == 2);
            wr_en     = (c == wr_cycle);
            if (busy) s_busy++;
            if (result_valid) begin
                s_pulses++;
                if (s_lat < 0) begin
                    s_lat = c; s_hit = result_hit; s_idx = result_idx; s_mult = result_mult;
                end
            end
            tick();
        end
        touchdown = 1'b0;
        wr_en     = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1; wr_en = 0; wr_idx = 0; wr_x = 0; wr_y = 0; wr_mult = 0;
        clear = 0; touchdown = 0; LanderX = 0; LanderY = 0;
        tick(); tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (pos_x[i] !== 16'hFFFF || pos_y[i] !== 16'hFFFF || mult[i] !== 3'd0) bad++;
        n_vec++;
        if (bad !== 0) begin n_fail++; $display("FAIL reset_slots: %0d slots not empty, want 0", bad); end
        n_vec++;
        if ({busy, result_valid, result_hit, result_idx, result_mult} !== {1'b0, 1'b0, 1'b0, 3'd0, 3'd1}) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b rv=%b hit=%b idx=%0d mult=%0d, want 0 0 0 0 1",
                     busy, result_valid, result_hit, result_idx, result_mult);
        end
        n_vec++;
        if (blink_on !== 1'b1) begin n_fail++; $display("FAIL reset_blink: got %b want 1", blink_on); end
    endtask

    task automatic test_single_hit();
        write_slot(3'd3, 16'd100, 16'd400, 3'd2);
        n_vec++;
        if (pos_x[3] !== 16'd100 || pos_y[3] !== 16'd400 || mult[3] !== 3'd2) begin
            n_fail++; $display("FAIL write_visible: got %0d,%0d,%0d want 100,400,2", pos_x[3], pos_y[3], mult[3]);
        end
        run_scan(16'd105, 16'd398, 1'b0, 0);
        n_vec++;
        if (s_lat !== 5 || s_busy !== 4) begin
            n_fail++; $display("FAIL hit3_timing: lat=%0d busy=%0d want 5 4", s_lat, s_busy);
        end
        n_vec++;
        if ({s_hit, s_idx, s_mult} !== {1'b1, 3'd3, 3'd2}) begin
            n_fail++; $display("FAIL hit3_result: hit=%b idx=%0d mult=%0d want 1 3 2", s_hit, s_idx, s_mult);
        end
        n_vec++;
        if ({result_hit, result_idx, result_mult} !== {1'b1, 3'd3, 3'd2}) begin
            n_fail++; $display("FAIL hit3_held: hit=%b idx=%0d mult=%0d want 1 3 2", result_hit, result_idx, result_mult);
        end
    endtask

    task automatic test_overlap_and_bounds();
        write_slot(3'd1, 16'd300, 16'd420, 3'd3);
        write_slot(3'd5, 16'd300, 16'd420, 3'd4);
        run_scan(16'd300, 16'd420, 1'b0, 0);
        n_vec++;
        if (s_lat !== 3 || {s_hit, s_idx, s_mult} !== {1'b1, 3'd1, 3'd3}) begin
            n_fail++; $display("FAIL overlap: lat=%0d hit=%b idx=%0d mult=%0d want 3 1 1 3", s_lat, s_hit, s_idx, s_mult);
        end
        run_scan(16'd308, 16'd420, 1'b0, 0);
        n_vec++;
        if (s_lat !== 9 || {s_hit, s_idx, s_mult} !== {1'b0, 3'd0, 3'd1}) begin
            n_fail++; $display("FAIL miss_x8: lat=%0d hit=%b idx=%0d mult=%0d want 9 0 0 1", s_lat, s_hit, s_idx, s_mult);
        end
        run_scan(16'd307, 16'd412, 1'b0, 0);
        n_vec++;
        if (s_lat !== 3 || {s_hit, s_idx} !== {1'b1, 3'd1}) begin
            n_fail++; $display("FAIL edge_x7_y8: lat=%0d hit=%b idx=%0d want 3 1 1", s_lat, s_hit, s_idx);
        end
        run_scan(16'd293, 16'd429, 1'b0, 0);
        n_vec++;
        if (s_hit !== 1'b0 || s_lat !== 9) begin
            n_fail++; $display("FAIL miss_y9: lat=%0d hit=%b want 9 0", s_lat, s_hit);
        end
        run_scan(16'd292, 16'd420, 1'b0, 0);
        n_vec++;
        if (s_hit !== 1'b0) begin n_fail++; $display("FAIL miss_neg_x8: hit=%b want 0", s_hit); end
    endtask

    task automatic test_back_to_back();
        run_scan(16'd105, 16'd398, 1'b1, 0);
        n_vec++;
        if (s_pulses !== 1 || s_lat !== 5 || s_idx !== 3'd3) begin
            n_fail++; $display("FAIL retrigger: pulses=%0d lat=%0d idx=%0d want 1 5 3", s_pulses, s_lat, s_idx);
        end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        write_slot(3'd0, 16'd50, 16'd50, 3'd4);
        clear = 1'b0;
        n_vec++;
        if (pos_x[0] !== 16'd50 || mult[0] !== 3'd4) begin
            n_fail++; $display("FAIL clear_keep0: x=%0d mult=%0d want 50 4", pos_x[0], mult[0]);
        end
        n_vec++;
        if (mult[1] !== 3'd0 || mult[3] !== 3'd0 || mult[5] !== 3'd0 || pos_x[3] !== 16'hFFFF) begin
            n_fail++; $display("FAIL clear_others: m1=%0d m3=%0d m5=%0d x3=%h want 0 0 0 ffff",
                               mult[1], mult[3], mult[5], pos_x[3]);
        end
        write_slot(3'd0, 16'd50, 16'd50, 3'd0);
        n_vec++;
        if (pos_x[0] !== 16'hFFFF || pos_y[0] !== 16'hFFFF) begin
            n_fail++; $display("FAIL invalidate0: x=%h y=%h want ffff ffff", pos_x[0], pos_y[0]);
        end
    endtask

    task automatic test_no_wrap();
        write_slot(3'd0, 16'd0, 16'd0, 3'd1);
        run_scan(16'hFFFF, 16'hFFFF, 1'b0, 0);
        n_vec++;
        if (s_hit !== 1'b0 || s_lat !== 9) begin
            n_fail++; $display("FAIL no_wrap: lat=%0d hit=%b want 9 0", s_lat, s_hit);
        end
        write_slot(3'd0, 16'd0, 16'd0, 3'd0);
    endtask

    task automatic test_write_during_scan();
        wr_idx = 3'd6; wr_x = 16'd1000; wr_y = 16'd1000; wr_mult = 3'd5;
        run_scan(16'd1000, 16'd1000, 1'b0, 1);
        n_vec++;
        if (s_lat !== 8 || {s_hit, s_idx, s_mult} !== {1'b1, 3'd6, 3'd5}) begin
            n_fail++; $display("FAIL midscan_write: lat=%0d hit=%b idx=%0d mult=%0d want 8 1 6 5", s_lat, s_hit, s_idx, s_mult);
        end
    endtask

    task automatic test_reset_midscan();
        int pulses;
        LanderX = 16'd1000; LanderY = 16'd1000; touchdown = 1'b1;
        tick();
        touchdown = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        #2;
        n_vec++;
        if (busy !== 1'b0 || mult[6] !== 3'd0) begin
            n_fail++; $display("FAIL async_reset: busy=%b mult6=%0d want 0 0", busy, mult[6]);
        end
        tick();
        Reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (result_valid) pulses++;
            tick();
        end
        n_vec++;
        if (pulses !== 0 || result_mult !== 3'd1) begin
            n_fail++; $display("FAIL abort_scan: pulses=%0d mult=%0d want 0 1", pulses, result_mult);
        end
    endtask

`ifdef MULT_BLINK_EN
    task automatic test_blink();
        int toggles, bad;
        logic prev;
        do_reset();
        write_slot(3'd2, 16'd10, 16'd20, 3'd4);
        prev = blink_on; toggles = 0; bad = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (blink_on !== prev) toggles++;
            if (!blink_on && pos_x[2] !== 16'hFFFF) bad++;
            if (blink_on && pos_x[2] !== 16'd10) bad++;
            if (mult[2] !== 3'd4) bad++;
            prev = blink_on;
        end
        n_vec++;
        if (toggles !== 6 || bad !== 0) begin
            n_fail++; $display("FAIL blink: toggles=%0d bad=%0d want 6 0", toggles, bad);
        end
        run_scan(16'd12, 16'd22, 1'b0, 0);
        n_vec++;
        if ({s_hit, s_idx, s_mult} !== {1'b1, 3'd2, 3'd4}) begin
            n_fail++; $display("FAIL blink_scan: hit=%b idx=%0d mult=%0d want 1 2 4", s_hit, s_idx, s_mult);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_hit();
        test_overlap_and_bounds();
        test_back_to_back();
        test_clear();
        test_no_wrap();
        test_write_during_scan();
        test_reset_midscan();
`ifdef MULT_BLINK_EN
        test_blink();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
